// File: rtl/riscv_mc_sequencer_if.sv
// Memory handshake and commit-enable bundle between the multi-cycle sequencer
// and the datapath / memory side.
interface riscv_mc_sequencer_if;
    logic imem_req;
    logic imem_ready;
    logic ir_we;
    logic dmem_req;
    logic dmem_ready;
    logic dmem_we;
    logic reg_we;
    logic pc_we;

    modport master (
        output imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we,
        input  imem_ready, dmem_ready
    );

    modport slave (
        input  imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we,
        output imem_ready, dmem_ready
    );
endinterface

// File: rtl/riscv_mc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer: gates PC, IR,
// register-file and data-memory commits, times out stalled accesses, traps.
module riscv_mc_sequencer #(
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    input  logic [6:0]               opcode,
    riscv_mc_sequencer_if.master     mem,
    output logic [2:0]               state_o,
    output logic [CNT_W-1:0]         retired,
    output logic                     trap,
    output logic [1:0]               trap_cause
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        C_ALU   = 2'd0,
        C_LOAD  = 2'd1,
        C_STORE = 2'd2
    } cls_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // Count value during the WAIT_MAX-th consecutive not-ready cycle.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_t     state, state_nx;
    cls_t       cls, cls_nx;
    logic [7:0] wait_cnt, wait_nx;
    logic [1:0] cause_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            cls        <= C_ALU;
            wait_cnt   <= '0;
            trap_cause <= '0;
            retired    <= '0;
        end else begin
            state      <= state_nx;
            cls        <= cls_nx;
            wait_cnt   <= wait_nx;
            trap_cause <= cause_nx;
            if (mem.pc_we)
                retired <= retired + CNT_W'(1);
        end
    end

    always_comb begin
        state_nx     = state;
        cls_nx       = cls;
        wait_nx      = wait_cnt;
        cause_nx     = trap_cause;
        mem.imem_req = 1'b0;
        mem.ir_we    = 1'b0;
        mem.dmem_req = 1'b0;
        mem.dmem_we  = 1'b0;
        mem.reg_we   = 1'b0;
        mem.pc_we    = 1'b0;

        case (state)
            S_IDLE: begin
                if (run)
                    state_nx = S_FETCH;
            end
            S_FETCH: begin
                mem.imem_req = 1'b1;
                if (mem.imem_ready) begin
                    mem.ir_we = 1'b1;
                    state_nx  = S_DECODE;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nx = S_TRAP;
                    cause_nx = 2'd2;
                end else begin
                    wait_nx = wait_cnt + 8'd1;
                end
            end
            S_DECODE: begin
                state_nx = S_EXECUTE;
                case (opcode)
                    OP_R, OP_I: cls_nx = C_ALU;
                    OP_LOAD:    cls_nx = C_LOAD;
                    OP_STORE:   cls_nx = C_STORE;
                    default: begin
                        state_nx = S_TRAP;
                        cause_nx = 2'd1;
                    end
                endcase
            end
            S_EXECUTE: begin
                state_nx = (cls == C_ALU) ? S_WRITEBACK : S_MEMORY;
            end
            S_MEMORY: begin
                mem.dmem_req = 1'b1;
                mem.dmem_we  = (cls == C_STORE);
                if (mem.dmem_ready) begin
                    // Stores commit in MEMORY; only loads need a WRITEBACK cycle.
                    if (cls == C_STORE) begin
                        mem.pc_we = 1'b1;
                        state_nx  = run ? S_FETCH : S_IDLE;
                    end else begin
                        state_nx = S_WRITEBACK;
                    end
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nx = S_TRAP;
                    cause_nx = 2'd3;
                end else begin
                    wait_nx = wait_cnt + 8'd1;
                end
            end
            S_WRITEBACK: begin
                mem.reg_we = 1'b1;
                mem.pc_we  = 1'b1;
                state_nx   = run ? S_FETCH : S_IDLE;
            end
            S_TRAP: begin
                state_nx = S_TRAP;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        if (state_nx != state)
            wait_nx = '0;
    end

    assign state_o = state;
    assign trap    = (state == S_TRAP);

endmodule

// File: tb/tb_riscv_mc_sequencer.sv
// Directed bench for riscv_mc_sequencer: table-driven instruction mix plus
// hand-written trap, timeout, wrap and async-reset sequences.
module tb_riscv_mc_sequencer;

    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;
    localparam logic [6:0] OP_L = 7'b0000011;
    localparam logic [6:0] OP_S = 7'b0100011;
    localparam logic [6:0] OP_J = 7'b1101111;

    logic        clk;
    logic        rst;
    logic        run;
    logic [6:0]  opcode;
    logic        ir;
    logic        dr;
    logic [2:0]  state_o, state4;
    logic [31:0] retired;
    logic [3:0]  retired4;
    logic        trap, trap4;
    logic [1:0]  trap_cause, cause4;

    int unsigned errors = 0;
    int unsigned checks = 0;

    riscv_mc_sequencer_if bus ();
    riscv_mc_sequencer_if bus4 ();

    assign bus.imem_ready  = ir;
    assign bus.dmem_ready  = dr;
    assign bus4.imem_ready = ir;
    assign bus4.dmem_ready = dr;

    riscv_mc_sequencer #(.WAIT_MAX(15), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem(bus),
        .state_o(state_o), .retired(retired), .trap(trap), .trap_cause(trap_cause)
    );

    riscv_mc_sequencer #(.WAIT_MAX(15), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode), .mem(bus4),
        .state_o(state4), .retired(retired4), .trap(trap4), .trap_cause(cause4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        run;
        logic [6:0]  op;
        logic        ir;
        logic        dr;
        logic [2:0]  st;
        logic [5:0]  en;   // {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we}
        logic [31:0] ret;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [5:0] en_now();
        return {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.reg_we, bus.pc_we};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; run = 1'b0; ir = 1'b1; dr = 1'b1; opcode = OP_R;
        #1;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_en", 32'(en_now()), 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_trap", {30'd0, trap_cause}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic add(input logic r, input logic [6:0] o, input logic i, input logic d,
                       input logic [2:0] s, input logic [5:0] e, input logic [31:0] rt);
        vec_t v;
        v.run = r; v.op = o; v.ir = i; v.dr = d; v.st = s; v.en = e; v.ret = rt;
        tbl.push_back(v);
    endtask

    initial begin
        // R-type, 8-cycle load with 3 stalls, store, 1-stall fetch of I-type, run drop
        add(0, OP_R, 1, 1, 0, 6'b000000, 0);
        add(1, OP_R, 1, 1, 0, 6'b000000, 0);
        add(1, OP_R, 1, 1, 1, 6'b110000, 0);
        add(1, OP_R, 1, 1, 2, 6'b000000, 0);
        add(1, OP_L, 1, 1, 3, 6'b000000, 0);
        add(1, OP_L, 1, 1, 5, 6'b000011, 0);
        add(1, OP_L, 1, 1, 1, 6'b110000, 1);
        add(1, OP_L, 1, 0, 2, 6'b000000, 1);
        add(1, OP_L, 1, 0, 3, 6'b000000, 1);
        add(1, OP_L, 1, 0, 4, 6'b001000, 1);
        add(1, OP_L, 1, 0, 4, 6'b001000, 1);
        add(1, OP_L, 1, 0, 4, 6'b001000, 1);
        add(1, OP_L, 1, 1, 4, 6'b001000, 1);
        add(1, OP_S, 1, 1, 5, 6'b000011, 1);
        add(1, OP_S, 1, 1, 1, 6'b110000, 2);
        add(1, OP_S, 1, 1, 2, 6'b000000, 2);
        add(1, OP_S, 1, 1, 3, 6'b000000, 2);
        add(1, OP_S, 1, 1, 4, 6'b001101, 2);
        add(1, OP_I, 0, 1, 1, 6'b100000, 3);
        add(1, OP_I, 1, 1, 1, 6'b110000, 3);
        add(1, OP_I, 1, 1, 2, 6'b000000, 3);
        add(1, OP_J, 1, 1, 3, 6'b000000, 3);
        add(0, OP_J, 1, 1, 5, 6'b000011, 3);
        add(0, OP_J, 1, 1, 0, 6'b000000, 4);
        add(0, OP_J, 1, 1, 0, 6'b000000, 4);

        do_reset();
        foreach (tbl[i]) begin
            run = tbl[i].run; opcode = tbl[i].op; ir = tbl[i].ir; dr = tbl[i].dr;
            #1;
            chk($sformatf("vec%0d_state", i), 32'(state_o), 32'(tbl[i].st));
            chk($sformatf("vec%0d_en", i), 32'(en_now()), 32'(tbl[i].en));
            chk($sformatf("vec%0d_retired", i), retired, tbl[i].ret);
            cyc();
        end

        // Illegal opcode: sticky trap, run ignored, only reset exits
        do_reset();
        run = 1'b1; opcode = OP_J;
        cyc(); cyc(); cyc();
        chk("illegal_state", 32'(state_o), 32'd6);
        chk("illegal_trap", {31'd0, trap}, 32'd1);
        chk("illegal_cause", {30'd0, trap_cause}, 32'd1);
        chk("illegal_en", 32'(en_now()), 32'd0);
        run = 1'b0; cyc();
        chk("illegal_run0", 32'(state_o), 32'd6);
        run = 1'b1; cyc();
        chk("illegal_run1", 32'(state_o), 32'd6);
        chk("illegal_cause_held", {30'd0, trap_cause}, 32'd1);
        rst = 1'b0; #1;
        chk("illegal_rst_state", 32'(state_o), 32'd0);
        chk("illegal_rst_trap", {29'd0, trap, trap_cause}, 32'd0);
        chk("illegal_rst_retired", retired, 32'd0);

        // imem timeout after 15 not-ready FETCH cycles
        do_reset();
        run = 1'b1; ir = 1'b0;
        cyc();
        for (int i = 0; i < 15; i++) begin
            #1 chk($sformatf("ifetch_wait%0d", i), 32'(state_o), 32'd1);
            cyc();
        end
        chk("imem_to_state", 32'(state_o), 32'd6);
        chk("imem_to_cause", {30'd0, trap_cause}, 32'd2);

        // ready on the 15th cycle wins over the timeout
        do_reset();
        run = 1'b1; ir = 1'b0;
        cyc();
        for (int i = 0; i < 15; i++) begin
            if (i == 14) ir = 1'b1;
            #1;
            if (i == 14) chk("late_ready_irwe", {31'd0, bus.ir_we}, 32'd1);
            cyc();
        end
        chk("late_ready_state", 32'(state_o), 32'd2);
        chk("late_ready_trap", {31'd0, trap}, 32'd0);

        // dmem timeout on a load
        do_reset();
        run = 1'b1; opcode = OP_L; dr = 1'b0;
        repeat (4) cyc();
        chk("dmem_wait_state", 32'(state_o), 32'd4);
        repeat (14) cyc();
        chk("dmem_wait_last", 32'(state_o), 32'd4);
        cyc();
        chk("dmem_to_state", 32'(state_o), 32'd6);
        chk("dmem_to_cause", {30'd0, trap_cause}, 32'd3);
        chk("dmem_to_retired", retired, 32'd0);

        // Back-to-back R-type; 4-bit counter wraps; reset during MEMORY
        do_reset();
        run = 1'b1; opcode = OP_R;
        repeat (13) cyc();
        chk("rtype_12cyc_retired", retired, 32'd3);
        chk("rtype_12cyc_state", 32'(state_o), 32'd1);
        repeat (48) cyc();
        chk("wrap_15", 32'(retired4), 32'd15);
        repeat (4) cyc();
        chk("wrap_0", 32'(retired4), 32'd0);
        chk("wrap_wide", retired, 32'd16);
        opcode = OP_L; dr = 1'b0;
        repeat (3) cyc();
        chk("midrst_mem", 32'(state_o), 32'd4);
        #3 rst = 1'b0;
        #1;
        chk("midrst_state", 32'(state_o), 32'd0);
        chk("midrst_en", 32'(en_now()), 32'd0);
        chk("midrst_retired", retired, 32'd0);
        chk("midrst_retired4", 32'(retired4), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_mc_sequencer.md
# riscv_mc_sequencer

Multi-cycle sequencer for the RISC-V IStype datapath (if/id/ex/dmem/wb stages plus controller). It steps one instruction at a time through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, gating the PC, IR, register-file and data-memory write enables. It waits on ready handshakes from instruction and data memory, times out stalled accesses, traps on unsupported opcodes and counts retired instructions. The combinational controller still produces ALUSel/ALUSrc/MemtoReg/selStore; this block only qualifies when state is committed.

## Interface
- WAIT_MAX, 15: max cycles a memory request may wait for ready before a timeout trap (1..255)
- CNT_W, 32: width of retired-instruction counter
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- run  in  1  level; sequencer leaves IDLE and keeps issuing while high
- opcode  in  7  instr[6:0] from the instruction register
- imem_ready  in  1  instruction memory data valid this cycle
- dmem_ready  in  1  data memory access complete this cycle
- imem_req  out  1  instruction fetch request
- ir_we  out  1  latch fetched word into IR
- dmem_req  out  1  data memory request
- dmem_we  out  1  data write strobe (gates MemRW)
- reg_we  out  1  register-file write qualifier (ANDed with RegWEn)
- pc_we  out  1  advance PC (pc+4)
- state_o  out  3  current state encoding
- retired  out  CNT_W  retired-instruction count
- trap  out  1  sticky trap flag
- trap_cause  out  2  0 none, 1 illegal opcode, 2 imem timeout, 3 dmem timeout

## Operation
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, TRAP=6.
- IDLE: run=1 -> FETCH; otherwise stay.
- FETCH: imem_req=1. imem_ready=1 -> ir_we=1 this cycle, next DECODE.
- DECODE: classify opcode. 0110011 (R), 0010011 (I-ALU), 0000011 (load) and 0100011 (store) -> EXECUTE. Any other opcode -> TRAP with cause 1.
- EXECUTE: one cycle. R/I-ALU -> WRITEBACK. Load/store -> MEMORY.
- MEMORY: dmem_req=1, and dmem_we=1 for store.
  - dmem_ready=1 on a load -> WRITEBACK.
  - dmem_ready=1 on a store -> pc_we=1 and retire this cycle, next FETCH if run=1, else IDLE.
- WRITEBACK: reg_we=1, pc_we=1, retire this cycle. Next FETCH if run=1, else IDLE.
- Wait counter: 8-bit, cleared on entry to FETCH or MEMORY, increments each cycle while ready is low.
  - Reaching WAIT_MAX with ready still low -> TRAP with cause 2 (FETCH) or 3 (MEMORY).
  - If ready=1 arrives in the same cycle the counter hits WAIT_MAX, ready wins and there is no trap.
- TRAP: all enables 0, trap=1, trap_cause held. Only rst exits TRAP; run is ignored.
- Opcode class is captured in DECODE, so opcode changes after DECODE have no effect.
- Retire: retired increments by 1 on every cycle with pc_we=1 and wraps modulo 2^CNT_W (all-ones -> 0).
- Enables are decoded from the state register plus same-cycle ready (Mealy only for ir_we, pc_we on store, MEMORY->next). At most one of ir_we, reg_we, dmem_we is high in any cycle.
- Dropping run mid-instruction finishes the current instruction, then goes to IDLE.

## Timing
- Reset (async assert, sync-released logic): state=IDLE, all enables 0, retired=0, trap=0, trap_cause=0, wait counter=0.
- Reset asserted mid-instruction aborts it with no partial retire; outputs go to reset values immediately.
- Cycle counts with ready high on the first request cycle:
  - R/I-ALU: 4 cycles (F, D, E, WB).
  - Load: 5 cycles (F, D, E, M, WB).
  - Store: 4 cycles (F, D, E, M).
- Each extra wait cycle adds 1.
- A timeout trap is entered on the cycle after the WAIT_MAX-th consecutive not-ready cycle.
- Back-to-back issue: the first FETCH of the next instruction follows the retire cycle directly, with no bubble.

## Test plan
- run=1, R-type opcode 0110011, imem_ready/dmem_ready tied 1 -> states 1,2,3,5 repeating; reg_we and pc_we high in the WB cycle; retired=3 after 12 cycles.
- Load 0000011 with dmem_ready low for 3 cycles -> MEMORY held 4 cycles; dmem_we=0; WB follows; total 8 cycles; retired +1.
- Store 0100011, dmem_ready=1 -> dmem_we=1 and pc_we=1 in the same MEMORY cycle; reg_we never high; next state FETCH.
- Opcode 1101111 in DECODE -> TRAP, trap=1, trap_cause=1; toggling run has no effect; rst low returns to IDLE with retired=0.
- imem_ready held 0, WAIT_MAX=15 -> trap_cause=2 after 15 FETCH cycles; repeat with ready=1 on the 15th cycle -> no trap, DECODE follows.
- CNT_W=4 with 16 R-type retires -> retired wraps 15->0; rst pulsed during MEMORY -> immediate IDLE, all enables 0.
